// File: rtl/logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter
//
// Shares one bitwise logic unit (NOT / AND / OR / XOR) among N_REQ requesters.
// A round-robin arbiter picks one request per IDLE visit. The request then
// walks through IDLE -> EXEC -> RESP. Its result is held on a single
// valid/ready response channel until the consumer accepts it.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   req_valid  in   [N_REQ]        per-requester request valid
//   req_ready  out  [N_REQ]        per-requester accept strobe (one-hot or zero)
//   req_op     in   [2*N_REQ]      op of requester i in [2i+1:2i]
//                                  00 NOT a, 01 AND, 10 OR, 11 XOR
//   req_a      in   [WIDTH*N_REQ]  operand a of requester i in [WIDTH*i +: WIDTH]
//   req_b      in   [WIDTH*N_REQ]  operand b, same packing (ignored for NOT)
//   rsp_valid  out  result valid
//   rsp_ready  in   consumer accepts result
//   rsp_data   out  [WIDTH]        registered result
//   rsp_id     out  [ID_W]         requester that owns rsp_data
//   busy       out  FSM not in IDLE
//   op_count   out  [16]           completed handshakes, wrapping
//                                  (only with LOGIC_ARB_OPCOUNT_EN defined)
//
// Optional feature macro: LOGIC_ARB_OPCOUNT_EN
// -----------------------------------------------------------------------------
module logic_unit_arbiter #(
  parameter int WIDTH = 16,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
`ifdef LOGIC_ARB_OPCOUNT_EN
  ,
  output logic [15:0]            op_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]    rr_ptr;
  logic [N_REQ-1:0]   rot;
  logic               found;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    ptr_nxt;
  logic [N_REQ-1:0]   grant_vec;
  logic [1:0]         sel_op;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  // Latched request (stage 0: captured at grant)
  logic [1:0]         op_p0;
  logic [WIDTH-1:0]   a_p0;
  logic [WIDTH-1:0]   b_p0;
  logic [ID_W-1:0]    id_p0;

  function automatic logic [WIDTH-1:0] logic_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = ~a;
      2'b01:   r = a & b;
      2'b10:   r = a | b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  // Round-robin search: rotate the valid vector so rr_ptr lands at bit 0,
  // take the first set bit, then map the offset back to an absolute index.
  always_comb begin
    logic [ID_W:0] sum;
    rot    = N_REQ'({req_valid, req_valid} >> rr_ptr);
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(N_REQ)) begin
          sum = sum - (ID_W+1)'(N_REQ);
        end
        winner = sum[ID_W-1:0];
      end
    end
  end

  assign ptr_nxt   = (winner == ID_W'(N_REQ-1)) ? '0 : winner + 1'b1;
  assign grant_vec = N_REQ'(1) << winner;
  // Reset masks the grant so nothing is accepted while reset is held.
  assign req_ready = (state_q == IDLE && found && !reset) ? grant_vec : '0;
  assign busy      = (state_q != IDLE);

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      op_p0     <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      id_p0     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      case (state_q)
        // Stage 0: capture the winner's request
        IDLE: begin
          if (found) begin
            op_p0  <= sel_op;
            a_p0   <= sel_a;
            b_p0   <= sel_b;
            id_p0  <= winner;
            rr_ptr <= ptr_nxt;
          end
        end
        // Stage 1: evaluate and register the result
        EXEC: begin
          rsp_data  <= logic_op(op_p0, a_p0, b_p0);
          rsp_id    <= id_p0;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef LOGIC_ARB_OPCOUNT_EN
  always_ff @(posedge clk) begin
    if (reset)                       op_count <= '0;
    else if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
  end
`endif

endmodule
